// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32x32 multiply/divide sequencer (MULT/MULTU/DIV/DIVU, HI/LO) for EX.
// Has no adder of its own. Every add/sub/invert step goes to the shared ALU through alu_*.
// EX hands the ALU to this block while busy=1, and the hazard unit stalls on busy.
//
// Optional feature: define MULDIV_SIGNED_EN to enable signed ops (op[1]=1). Signed ops use
// sign-magnitude: PRE_A/PRE_B take the magnitudes, and POST_LO/POST_HI fix the signs.
// When MULDIV_SIGNED_EN is undefined, op[1] is ignored and every op is unsigned.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, op, a, b     launch request; accepted only while busy=0 (IDLE or DONE)
//                       op[0]: 0=mul 1=div, op[1]: 1=signed
//   busy                op in progress, ALU owned by this block
//   done                one-cycle pulse; hi/lo/div_by_zero valid from this cycle on
//   hi, lo              product[63:32]/remainder, product[31:0]/quotient
//   div_by_zero         last div had b==0; held until the next accept
//   alu_con/in1/in2     request to shared ALU (E=addu, F=subu, 5=xnor)
//   alu_result          combinational ALU result for the current request
module muldiv_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero,
   output logic [3:0]       alu_con,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   input  logic [WIDTH-1:0] alu_result
);

`ifdef MULDIV_SIGNED_EN
   localparam bit SignedEn = 1'b1;
`else
   localparam bit SignedEn = 1'b0;
`endif

   localparam logic [3:0] AluAddu = 4'hE;
   localparam logic [3:0] AluSubu = 4'hF;
   localparam logic [3:0] AluXnor = 4'h5;
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPreA,
      StPreB,
      StRun,
      StPostLo,
      StPostHi,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic [WIDTH-1:0]  b_q, b_d;          // multiplicand / divisor (magnitude after PRE_B)
   logic              is_div_q, is_div_d;
   logic              is_signed_q, is_signed_d;
   logic              sign_a_q, sign_a_d;
   logic              sign_b_q, sign_b_d;
   logic              lo_zero_q, lo_zero_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              dbz_q, dbz_d;

   logic [WIDTH-1:0]  r_sh;
   logic              div_ok;
   logic              mul_carry;
   logic              negate;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      b_d         = b_q;
      is_div_d    = is_div_q;
      is_signed_d = is_signed_q;
      sign_a_d    = sign_a_q;
      sign_b_d    = sign_b_q;
      lo_zero_d   = lo_zero_q;
      dbz_d       = dbz_q;

      alu_con = AluAddu;
      alu_in1 = '0;
      alu_in2 = '0;

      // Partial remainder shifted left by one; hi_q[WIDTH-1] is its implicit 33rd bit.
      r_sh      = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      div_ok    = 1'b0;
      mul_carry = 1'b0;
      negate    = sign_a_q ^ sign_b_q;

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               is_div_d    = op[0];
               is_signed_d = op[1] & SignedEn;
               sign_a_d    = a[WIDTH-1];
               sign_b_d    = b[WIDTH-1];
               b_d         = b;
               cnt_d       = '0;
               dbz_d       = 1'b0;
               if (op[0] && (b == '0)) begin
                  hi_d    = a;
                  lo_d    = '1;
                  dbz_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  hi_d    = '0;
                  lo_d    = a;
                  state_d = (op[1] & SignedEn) ? StPreA : StRun;
               end
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end

         StPreA: begin
            alu_con = AluSubu;
            alu_in2 = lo_q;
            if (sign_a_q) lo_d = alu_result;
            state_d = StPreB;
         end

         StPreB: begin
            alu_con = AluSubu;
            alu_in2 = b_q;
            if (sign_b_q) b_d = alu_result;
            state_d = StRun;
         end

         StRun: begin
            if (is_div_q) begin
               alu_con = AluSubu;
               alu_in1 = r_sh;
               alu_in2 = b_q;
               // No borrow when the difference did not wrap above r_sh.
               div_ok  = hi_q[WIDTH-1] | (alu_result <= r_sh);
               if (div_ok) begin
                  hi_d = alu_result;
                  lo_d = {lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  hi_d = r_sh;
                  lo_d = {lo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               alu_con = AluAddu;
               alu_in1 = hi_q;
               alu_in2 = b_q;
               if (lo_q[0]) begin
                  mul_carry = (alu_result < hi_q);
                  hi_d      = {mul_carry, alu_result[WIDTH-1:1]};
                  lo_d      = {alu_result[0], lo_q[WIDTH-1:1]};
               end else begin
                  hi_d = {1'b0, hi_q[WIDTH-1:1]};
                  lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
               end
            end
            if (cnt_q == LastCnt) begin
               cnt_d   = '0;
               state_d = is_signed_q ? StPostLo : StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         StPostLo: begin
            alu_con   = AluSubu;
            alu_in2   = lo_q;
            lo_zero_d = (lo_q == '0);
            if (negate) lo_d = alu_result;
            state_d = StPostHi;
         end

         StPostHi: begin
            // Negating a 64-bit value: the high word needs the borrow only when lo was zero,
            // otherwise it is just inverted.
            if (is_div_q || lo_zero_q) begin
               alu_con = AluSubu;
               alu_in2 = hi_q;
            end else begin
               alu_con = AluXnor;
               alu_in1 = hi_q;
            end
            if (is_div_q) begin
               if (sign_a_q) hi_d = alu_result;
            end else if (negate) begin
               hi_d = alu_result;
            end
            state_d = StDone;
         end

         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StPreA) || (state_d == StPreB) || (state_d == StRun) ||
               (state_d == StPostLo) || (state_d == StPostHi);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         b_q         <= '0;
         is_div_q    <= 1'b0;
         is_signed_q <= 1'b0;
         sign_a_q    <= 1'b0;
         sign_b_q    <= 1'b0;
         lo_zero_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         b_q         <= b_d;
         is_div_q    <= is_div_d;
         is_signed_q <= is_signed_d;
         sign_a_q    <= sign_a_d;
         sign_b_q    <= sign_b_d;
         lo_zero_q   <= lo_zero_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq. The stimulus pushes the expected hi/lo/div_by_zero/latency
// for each issued op. A monitor pops one entry and compares it on every done pulse.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;
   logic [3:0]  alu_con;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [31:0] alu_result;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   logic        alu_chk = 1'b0;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int unsigned lat;
      int unsigned acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   muldiv_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero),
      .alu_con     (alu_con),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_result  (alu_result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared ALU model
   always_comb begin
      alu_result = '0;
      case (alu_con)
         4'hE:    alu_result = alu_in1 + alu_in2;
         4'hF:    alu_result = alu_in1 - alu_in2;
         4'h5:    alu_result = ~(alu_in1 ^ alu_in2);
         default: alu_result = '0;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h required %08h", nm, act, exp);
      end
   endtask

   // Caller is at a negedge. Returns at the negedge after the accept edge.
   task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input logic ed, input int unsigned lat, input bit track);
      exp_t e;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      if (track) begin
         e.name = nm;
         e.hi   = eh;
         e.lo   = el;
         e.dbz  = ed;
         e.lat  = lat;
         e.acc  = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got %0d pending ops required 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 required done=0 (no op pending)");
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_hi"}, hi, mon_e.hi);
            chk({mon_e.name, "_lo"}, lo, mon_e.lo);
            chk({mon_e.name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
            chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (alu_chk && busy) chk("divu_run_alu_con", {28'd0, alu_con}, 32'hF);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish before 200000ns");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      chk("idle_alu_con", {28'd0, alu_con}, 32'hE);
      chk("idle_alu_in1", alu_in1, 32'd0);
      chk("idle_alu_in2", alu_in2, 32'd0);
      rst = 1'b0;

      issue("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0,
            32, 1'b1);
      wait_idle();

      alu_chk = 1'b1;
      issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0, 32, 1'b1);
      wait_idle();
      alu_chk = 1'b0;

      issue("divu_by_zero", 2'b01, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 1'b1,
            0, 1'b1);
      wait_idle();
      chk("dbz_held", {31'd0, div_by_zero}, 32'd1);
      chk("dbz_idle_busy", {31'd0, busy}, 32'd0);

      issue("multu_7_6", 2'b00, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0, 32, 1'b1);
      wait_idle();
      issue("multu_2p16_sq", 2'b00, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 1'b0, 32, 1'b1);
      wait_idle();
      issue("multu_max_2", 2'b00, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 1'b0, 32, 1'b1);
      wait_idle();
      issue("divu_max_1", 2'b01, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 1'b0, 32, 1'b1);
      wait_idle();
      issue("divu_5_9", 2'b01, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0, 32, 1'b1);
      wait_idle();
      issue("divu_msb_3", 2'b01, 32'h80000000, 32'd3, 32'd2, 32'h2AAAAAAA, 1'b0, 32, 1'b1);
      wait_idle();

      // A start while busy must be ignored and must not re-latch operands.
      issue("multu_busy_ign", 2'b00, 32'h1234, 32'h10, 32'h0, 32'h12340, 1'b0, 32, 1'b1);
      repeat (5) @(negedge clk);
      start = 1'b1;
      op    = 2'b01;
      a     = 32'hFFFFFFFF;
      b     = 32'hFFFFFFFF;
      @(negedge clk);
      start = 1'b0;
      chk("ignored_start_busy", {31'd0, busy}, 32'd1);
      wait_idle();
      repeat (3) @(negedge clk);

      // A start in the DONE cycle is accepted, so busy is high in the next cycle.
      issue("divu_b2b_first", 2'b01, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0, 32, 1'b1);
      for (int i = 0; i < 100 && !done; i++) @(negedge clk);
      chk("b2b_done_seen", {31'd0, done}, 32'd1);
      issue("multu_b2b_second", 2'b00, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0, 32, 1'b1);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      wait_idle();

      // Asynchronous reset in the middle of RUN (cnt=10).
      issue("multu_aborted", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      repeat (10) @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_hi", hi, 32'd0);
      chk("mid_rst_lo", lo, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      issue("multu_3_5", 2'b00, 32'd3, 32'd5, 32'h0, 32'hF, 1'b0, 32, 1'b1);
      wait_idle();

`ifdef MULDIV_SIGNED_EN
      issue("mult_m3_5", 2'b10, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 36,
            1'b1);
      wait_idle();
      issue("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 36, 1'b1);
      wait_idle();
      issue("mult_m1_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 36, 1'b1);
      wait_idle();
      issue("div_signed_zero", 2'b11, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 0,
            1'b1);
      wait_idle();
`endif

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
